zn_wlx_fsk_demod_ctrl: RTL and testbench

Bit-level controller for the FSK receive path. It consumes the period measurements produced by the frequency-detect datapath (one count per input waveform cycle) and classifies each as mark or space. It times fixed-length bit windows and majority-votes inside each window. It hunts for a sync byte, then delivers aligned data bytes, and drops lock when the carrier disappears.

---
 rtl/zn_wlx_fsk_demod_ctrl.sv | 177 +++++++++++++++++
 tb/tb_zn_wlx_fsk_demod_ctrl.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/zn_wlx_fsk_demod_ctrl.sv
// FSK bit-level receive controller: mark/space voting per bit window,
// sync-word hunt, byte framing and carrier-loss timeout.
module zn_wlx_fsk_demod_ctrl #(
   parameter logic [15:0] PERIOD_SPLIT    = 16'd40,
   parameter logic [15:0] SAMPLES_PER_BIT = 16'd200,
   parameter logic [7:0]  SYNC_WORD       = 8'h7E,
   parameter logic [15:0] TIMEOUT         = 16'd2000
) (
   input  logic        sample_clk,
   input  logic        rst,
   input  logic        enable,
   input  logic [15:0] period_in,
   input  logic        period_valid,
   output logic [7:0]  byte_out,
   output logic        byte_valid,
   output logic        locked,
   output logic        carrier_lost
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_HUNT,
      S_DATA
   } state_e;

   state_e      state_q, state_d;
   logic [15:0] bit_cnt_q, bit_cnt_d;
   logic [15:0] idle_q, idle_d;
   logic [7:0]  ones_q, ones_d;
   logic [7:0]  zeros_q, zeros_d;
   logic        prev_q, prev_d;
   logic [6:0]  sr_q, sr_d;
   logic [2:0]  bits_q, bits_d;
   logic [7:0]  byte_q, byte_d;
   logic        bv_q, bv_d;
   logic        lock_q, lock_d;
   logic        cl_q, cl_d;

   logic        cls;
   logic        win_end;
   logic        tmo;
   logic        realign;
   logic [7:0]  ones_v;
   logic [7:0]  zeros_v;
   logic        bit_v;
   logic [7:0]  word_v;

   assign cls     = period_in < PERIOD_SPLIT;
   assign win_end = bit_cnt_q == (SAMPLES_PER_BIT - 16'd1);
   assign tmo     = (idle_q == (TIMEOUT - 16'd1)) && !period_valid;
   assign realign = (state_q == S_HUNT) && period_valid
                    && (cls != prev_q);

   // Votes including this cycle's strobe, saturating at 255.
   always_comb begin
      ones_v  = ones_q;
      zeros_v = zeros_q;
      if (period_valid && cls && ones_q != 8'hFF)
         ones_v = ones_q + 8'd1;
      if (period_valid && !cls && zeros_q != 8'hFF)
         zeros_v = zeros_q + 8'd1;
   end

   assign bit_v  = ones_v > zeros_v;
   assign word_v = {sr_q, bit_v};

   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      idle_d    = idle_q;
      ones_d    = ones_q;
      zeros_d   = zeros_q;
      prev_d    = prev_q;
      sr_d      = sr_q;
      bits_d    = bits_q;
      byte_d    = byte_q;
      bv_d      = 1'b0;
      lock_d    = lock_q;
      cl_d      = 1'b0;
      if (!enable) begin
         state_d   = S_IDLE;
         bit_cnt_d = '0;
         idle_d    = '0;
         ones_d    = '0;
         zeros_d   = '0;
         prev_d    = 1'b0;
         sr_d      = '0;
         bits_d    = '0;
         byte_d    = '0;
         lock_d    = 1'b0;
      end else begin
         unique case (state_q)
            S_IDLE: state_d = S_HUNT;
            S_HUNT, S_DATA: begin
               idle_d = period_valid ? 16'd0 : idle_q + 16'd1;
               if (period_valid)
                  prev_d = cls;
               if (tmo) begin
                  cl_d      = 1'b1;
                  lock_d    = 1'b0;
                  state_d   = S_HUNT;
                  idle_d    = '0;
                  bit_cnt_d = '0;
                  ones_d    = '0;
                  zeros_d   = '0;
                  sr_d      = '0;
                  bits_d    = '0;
               end else if (realign) begin
                  // Triggering strobe occupies slot 0 of the new window.
                  bit_cnt_d = 16'd1;
                  ones_d    = {7'd0, cls};
                  zeros_d   = {7'd0, !cls};
               end else if (win_end) begin
                  bit_cnt_d = '0;
                  ones_d    = '0;
                  zeros_d   = '0;
                  sr_d      = word_v[6:0];
                  if (state_q == S_HUNT) begin
                     if (word_v == SYNC_WORD) begin
                        lock_d  = 1'b1;
                        state_d = S_DATA;
                        bits_d  = '0;
                     end
                  end else if (bits_q == 3'd7) begin
                     byte_d = word_v;
                     bv_d   = 1'b1;
                     bits_d = '0;
                  end else begin
                     bits_d = bits_q + 3'd1;
                  end
               end else begin
                  bit_cnt_d = bit_cnt_q + 16'd1;
                  ones_d    = ones_v;
                  zeros_d   = zeros_v;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge sample_clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         bit_cnt_q <= '0;
         idle_q    <= '0;
         ones_q    <= '0;
         zeros_q   <= '0;
         prev_q    <= 1'b0;
         sr_q      <= '0;
         bits_q    <= '0;
         byte_q    <= '0;
         bv_q      <= 1'b0;
         lock_q    <= 1'b0;
         cl_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         idle_q    <= idle_d;
         ones_q    <= ones_d;
         zeros_q   <= zeros_d;
         prev_q    <= prev_d;
         sr_q      <= sr_d;
         bits_q    <= bits_d;
         byte_q    <= byte_d;
         bv_q      <= bv_d;
         lock_q    <= lock_d;
         cl_q      <= cl_d;
      end
   end

   assign byte_out     = byte_q;
   assign byte_valid   = bv_q;
   assign locked       = lock_q;
   assign carrier_lost = cl_q;

endmodule

// File: tb/tb_zn_wlx_fsk_demod_ctrl.sv
// Directed bench for zn_wlx_fsk_demod_ctrl with 16-cycle bits,
// 64-cycle timeout and a strobe every 4 cycles.
module tb_zn_wlx_fsk_demod_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        enable;
   logic [15:0] period_in;
   logic        period_valid;
   logic [7:0]  byte_out;
   logic        byte_valid;
   logic        locked;
   logic        carrier_lost;

   int checks = 0;
   int fails  = 0;
   int bv_total = 0;
   int cl_total = 0;

   always #5 clk = ~clk;

   zn_wlx_fsk_demod_ctrl #(
      .PERIOD_SPLIT    (16'd40),
      .SAMPLES_PER_BIT (16'd16),
      .SYNC_WORD       (8'h7E),
      .TIMEOUT         (16'd64)
   ) dut (
      .sample_clk   (clk),
      .rst          (rst),
      .enable       (enable),
      .period_in    (period_in),
      .period_valid (period_valid),
      .byte_out     (byte_out),
      .byte_valid   (byte_valid),
      .locked       (locked),
      .carrier_lost (carrier_lost)
   );

   always @(negedge clk) begin
      if (byte_valid === 1'b1) bv_total++;
      if (carrier_lost === 1'b1) cl_total++;
   end

   task automatic tick(input logic pv, input logic [15:0] p);
      period_valid = pv;
      period_in    = p;
      @(posedge clk);
      #1;
   endtask

   task automatic send_bit(input logic b);
      for (int k = 0; k < 16; k++)
         tick(k % 4 == 0, b ? 16'd30 : 16'd60);
   endtask

   task automatic send_votes(input logic [3:0] v);
      for (int k = 0; k < 16; k++)
         tick(k % 4 == 0, v[3 - k / 4] ? 16'd30 : 16'd60);
   endtask

   task automatic send_byte(input logic [7:0] b);
      for (int i = 7; i >= 0; i--)
         send_bit(b[i]);
   endtask

   task automatic test_reset;
      int bv0;
      int cl0;
      rst = 1'b1;
      enable = 1'b0;
      repeat (3) tick(1'b0, 16'd0);
      checks++;
      if (byte_out !== 8'h00) begin
         fails++;
         $display("FAIL rst_byte_out: got %h exp 00", byte_out);
      end
      checks++;
      if (byte_valid !== 1'b0) begin
         fails++;
         $display("FAIL rst_byte_valid: got %b exp 0", byte_valid);
      end
      checks++;
      if (locked !== 1'b0) begin
         fails++;
         $display("FAIL rst_locked: got %b exp 0", locked);
      end
      checks++;
      if (carrier_lost !== 1'b0) begin
         fails++;
         $display("FAIL rst_carrier: got %b exp 0", carrier_lost);
      end
      rst = 1'b0;
      bv0 = bv_total;
      cl0 = cl_total;
      repeat (5) send_bit(1'b1);
      repeat (80) tick(1'b0, 16'd60);
      #5;
      checks++;
      if (bv_total - bv0 !== 0) begin
         fails++;
         $display("FAIL idle_bv: got %0d exp 0", bv_total - bv0);
      end
      checks++;
      if (cl_total - cl0 !== 0) begin
         fails++;
         $display("FAIL idle_cl: got %0d exp 0", cl_total - cl0);
      end
      checks++;
      if (locked !== 1'b0) begin
         fails++;
         $display("FAIL idle_locked: got %b exp 0", locked);
      end
   endtask

   task automatic test_sync_data;
      int bv0;
      logic [7:0] sw;
      sw = 8'h7E;
      bv0 = bv_total;
      enable = 1'b1;
      tick(1'b0, 16'd60);
      for (int i = 7; i >= 1; i--)
         send_bit(sw[i]);
      checks++;
      if (locked !== 1'b0) begin
         fails++;
         $display("FAIL pre_sync_locked: got %b exp 0", locked);
      end
      send_bit(sw[0]);
      checks++;
      if (locked !== 1'b1) begin
         fails++;
         $display("FAIL sync_locked: got %b exp 1", locked);
      end
      send_byte(8'hA5);
      checks++;
      if (byte_valid !== 1'b1) begin
         fails++;
         $display("FAIL a5_valid: got %b exp 1", byte_valid);
      end
      checks++;
      if (byte_out !== 8'hA5) begin
         fails++;
         $display("FAIL a5_byte: got %h exp a5", byte_out);
      end
      #5;
      checks++;
      if (bv_total - bv0 !== 1) begin
         fails++;
         $display("FAIL a5_count: got %0d exp 1", bv_total - bv0);
      end
   endtask

   task automatic test_vote_majority;
      int bv0;
      bv0 = bv_total;
      send_votes(4'b1101);
      send_votes(4'b1010);
      send_votes(4'b0111);
      send_votes(4'b0011);
      send_bit(1'b1);
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b0);
      checks++;
      if (byte_valid !== 1'b1) begin
         fails++;
         $display("FAIL vote_valid: got %b exp 1", byte_valid);
      end
      checks++;
      if (byte_out !== 8'hAC) begin
         fails++;
         $display("FAIL vote_byte: got %h exp ac", byte_out);
      end
      #5;
      checks++;
      if (bv_total - bv0 !== 1) begin
         fails++;
         $display("FAIL vote_count: got %0d exp 1", bv_total - bv0);
      end
   endtask

   task automatic test_carrier_loss;
      int bv0;
      int cl0;
      int hit;
      bv0 = bv_total;
      cl0 = cl_total;
      hit = 0;
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      // last strobe was 3 edges ago; timeout due 64 edges after it
      for (int n = 1; n <= 100; n++) begin
         tick(1'b0, 16'd60);
         if (carrier_lost === 1'b1) begin
            hit = n;
            break;
         end
      end
      checks++;
      if (hit !== 61) begin
         fails++;
         $display("FAIL cl_time: got %0d exp 61", hit);
      end
      checks++;
      if (locked !== 1'b0) begin
         fails++;
         $display("FAIL cl_locked: got %b exp 0", locked);
      end
      tick(1'b0, 16'd60);
      checks++;
      if (carrier_lost !== 1'b0) begin
         fails++;
         $display("FAIL cl_width: got %b exp 0", carrier_lost);
      end
      #5;
      checks++;
      if (bv_total - bv0 !== 0) begin
         fails++;
         $display("FAIL cl_bv: got %0d exp 0", bv_total - bv0);
      end
      checks++;
      if (cl_total - cl0 !== 1) begin
         fails++;
         $display("FAIL cl_count: got %0d exp 1", cl_total - cl0);
      end
      send_byte(8'h7E);
      checks++;
      if (locked !== 1'b1) begin
         fails++;
         $display("FAIL resync_locked: got %b exp 1", locked);
      end
   endtask

   task automatic test_collision;
      int bv0;
      int cl0;
      int hit;
      logic [6:0] pre;
      bv0 = bv_total;
      cl0 = cl_total;
      hit = 0;
      pre = 7'b1100110;
      for (int i = 6; i >= 0; i--)
         send_bit(pre[i]);
      // two marks, one space, then a space on the window-end cycle
      for (int k = 0; k < 16; k++) begin
         if (k == 0 || k == 4)
            tick(1'b1, 16'd30);
         else if (k == 8 || k == 15)
            tick(1'b1, 16'd60);
         else
            tick(1'b0, 16'd60);
      end
      checks++;
      if (byte_valid !== 1'b1) begin
         fails++;
         $display("FAIL col_valid: got %b exp 1", byte_valid);
      end
      checks++;
      if (byte_out !== 8'hCC) begin
         fails++;
         $display("FAIL col_byte: got %h exp cc", byte_out);
      end
      for (int n = 1; n <= 100; n++) begin
         tick(1'b0, 16'd60);
         if (carrier_lost === 1'b1) begin
            hit = n;
            break;
         end
      end
      checks++;
      if (hit !== 64) begin
         fails++;
         $display("FAIL col_time: got %0d exp 64", hit);
      end
      checks++;
      if (locked !== 1'b0) begin
         fails++;
         $display("FAIL col_locked: got %b exp 0", locked);
      end
      checks++;
      if (byte_out !== 8'hCC) begin
         fails++;
         $display("FAIL col_hold: got %h exp cc", byte_out);
      end
      tick(1'b0, 16'd60);
      #5;
      checks++;
      if (bv_total - bv0 !== 1) begin
         fails++;
         $display("FAIL col_bv: got %0d exp 1", bv_total - bv0);
      end
      checks++;
      if (cl_total - cl0 !== 1) begin
         fails++;
         $display("FAIL col_cl: got %0d exp 1", cl_total - cl0);
      end
   endtask

   task automatic test_enable_drop;
      int bv0;
      send_byte(8'h7E);
      checks++;
      if (locked !== 1'b1) begin
         fails++;
         $display("FAIL en_pre_locked: got %b exp 1", locked);
      end
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      enable = 1'b0;
      tick(1'b0, 16'd60);
      enable = 1'b1;
      tick(1'b0, 16'd60);
      checks++;
      if (locked !== 1'b0) begin
         fails++;
         $display("FAIL en_locked: got %b exp 0", locked);
      end
      checks++;
      if (byte_out !== 8'h00) begin
         fails++;
         $display("FAIL en_byte: got %h exp 00", byte_out);
      end
      #5;
      bv0 = bv_total;
      send_byte(8'hA5);
      #5;
      checks++;
      if (bv_total - bv0 !== 0) begin
         fails++;
         $display("FAIL en_hunt_bv: got %0d exp 0", bv_total - bv0);
      end
      checks++;
      if (locked !== 1'b0) begin
         fails++;
         $display("FAIL en_hunt_locked: got %b exp 0", locked);
      end
      checks++;
      if (byte_out !== 8'h00) begin
         fails++;
         $display("FAIL en_hunt_byte: got %h exp 00", byte_out);
      end
      send_byte(8'h7E);
      checks++;
      if (locked !== 1'b1) begin
         fails++;
         $display("FAIL en_relock: got %b exp 1", locked);
      end
   endtask

   initial begin
      rst = 1'b1;
      enable = 1'b0;
      period_in = 16'd0;
      period_valid = 1'b0;
      test_reset;
      test_sync_data;
      test_vote_majority;
      test_carrier_loss;
      test_collision;
      test_enable_drop;
      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
